i2c_bus_monitor_fifo: RTL and testbench
=======================================

Name: i2c_bus_monitor_fifo

Overview:
Passive I2C bus monitor on the core clock domain; never drives the bus.
- Synchronises and glitch-filters SCL/SDA, detects START / repeated START / STOP, and deserialises address and data bytes with their ACK bit.
- Pushes typed events into a parametrised FIFO drained by a valid/ready consumer (scoreboard bridge or APB status logic).
- Generalised successor of the current slave-side start/stop/data_read_valid outputs: adds event typing, ACK capture, filtering, buffering and overflow reporting.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per line (min 2).
- FILTER_LEN, 3, consecutive stable cycles required before a filtered line changes (min 1).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, min 2).

Ports:
- i2c_core_clock  in  1  sole clock.
- preset  in  1  synchronous reset, active-high.
- enable  in  1  monitor enable.
- scl_i  in  1  raw SCL bus sample.
- sda_i  in  1  raw SDA bus sample.
- evt_ready  in  1  consumer ready.
- clr_overflow  in  1  clears overflow.
- evt_valid  out  1  FIFO head valid.
- evt_type  out  3  1=START 2=ADDR 3=DATA 4=RSTART 5=STOP.
- evt_data  out  8  byte, MSB first on bus; 0 for START/RSTART/STOP.
- evt_ack  out  1  1 = ACK (SDA low in 9th bit); 0 for non-byte events.
- evt_err  out  1  START/RSTART/STOP that truncated a partial byte.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- overflow  out  1  sticky: event dropped on full FIFO.
- start_pulse  out  1  one-cycle pulse on START or RSTART.
- stop_pulse  out  1  one-cycle pulse on STOP.
- bus_busy  out  1  high from START to STOP.

Behaviour:
Reset:
- Synchroniser and filter state reset to 1 (idle-high bus).
- FSM → IDLE; FIFO empty; every output 0.

Conditioning:
- Filtered line takes the synchronised value once it has been stable FILTER_LEN consecutive cycles.
- Latency raw → filtered = SYNC_STAGES + FILTER_LEN cycles.
- Pulses shorter than FILTER_LEN cycles are ignored.

Edge detection:
- Based on filtered previous/current values.
- START/RSTART = SDA falling while SCL high in both previous and current cycle.
- STOP = SDA rising under the same SCL condition.
- If SCL and SDA both change in one cycle, only the SCL edge is honoured.
- Data bits are sampled on SCL rising edge.

FSM (states IDLE, ADDR, ACK_A, DATA, ACK_D; bitcnt 0..7):
- IDLE: START → push START, bus_busy=1, go ADDR, bitcnt=0.
- ADDR/DATA: each SCL rise shifts SDA into the shift register MSB-first; on the 8th bit go ACK_A/ACK_D.
- ACK_A/ACK_D: SCL rise samples SDA, evt_ack=~SDA, pushes ADDR/DATA with the byte, then goes DATA, bitcnt=0.
- START in any non-IDLE state: push RSTART, go ADDR.
- STOP in any state except IDLE: push STOP, bus_busy=0, go IDLE.
- evt_err=1 on the RSTART/STOP entry when it arrives in ADDR/DATA with bitcnt≠0, or in an ACK state.
- STOP in IDLE: pulse only, no push.
- start_pulse/stop_pulse are asserted the cycle the edge is detected, independent of FIFO state.

Enable:
- enable=0 forces IDLE, clears bus_busy, suppresses pushes and pulses.
- FIFO still drains.
- Deassertion mid-byte discards the partial byte with no event.

FIFO:
- Outputs are registered FIFO head (show-ahead): evt_valid = level≠0.
- Pop on evt_valid && evt_ready.
- Push latency: event visible at head the cycle after detection when the FIFO was empty.
- Push when full and no pop: entry dropped, overflow set.
- Push and pop in the same cycle when full: both occur, no overflow.
- Push and pop in the same cycle when empty: push only.
- Overflow clears on clr_overflow; set wins over a simultaneous clear.

Reset mid-operation:
- Synchronous reset in any state returns to the reset values above on the next edge; FIFO contents are lost.

Test Plan:
- Write 0xA0 ACK, 0x5A ACK, STOP, evt_ready=1 → events START; ADDR 0xA0 ack=1; DATA 0x5A ack=1; STOP err=0; bus_busy 1→0.
- Read 0xA1 ACK, data 0xFF NACK, STOP → DATA 0xFF ack=0; fifo_level peaks ≤4.
- START, ADDR 0x50, three data bits, repeated START, ADDR 0x51 → RSTART with err=1, then ADDR 0x51; start_pulse asserted twice.
- 2-cycle low glitch on SDA while SCL high (FILTER_LEN=3) → no START, no pulse, state IDLE.
- evt_ready=0 for 10 events with FIFO_DEPTH=8 → level=8, overflow=1, first 8 events retained in order; clr_overflow with no push → overflow=0.
- Assert preset mid-data-byte → next cycle evt_valid=0, fifo_level=0, bus_busy=0; next START decodes normally.

Source files
------------

// File: rtl/i2c_bus_monitor_fifo.sv
// i2c_bus_monitor_fifo: passive I2C monitor that decodes bus events into a show-ahead event FIFO
// Ports: i2c_core_clock/preset (sync, active-high) clock and reset; enable gates decoding;
//        scl_i/sda_i raw bus samples; evt_valid/evt_ready/evt_* FIFO head and handshake;
//        fifo_level occupancy; overflow sticky drop flag cleared by clr_overflow;
//        start_pulse/stop_pulse one-cycle condition strobes; bus_busy high between START and STOP.
module i2c_bus_monitor_fifo #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                             i2c_core_clock,
  input  logic                             preset,
  input  logic                             enable,
  input  logic                             scl_i,
  input  logic                             sda_i,
  input  logic                             evt_ready,
  input  logic                             clr_overflow,
  output logic                             evt_valid,
  output logic [2:0]                       evt_type,
  output logic [7:0]                       evt_data,
  output logic                             evt_ack,
  output logic                             evt_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             overflow,
  output logic                             start_pulse,
  output logic                             stop_pulse,
  output logic                             bus_busy
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D} state_t;
  logic [1:0] raw, filt, prev;
  assign raw = {scl_i, sda_i};
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic f;
    // The filtered line only follows the synchronised value after it has differed for FILTER_LEN cycles in a row
    always_ff @(posedge i2c_core_clock)
      if (preset) begin
        sync <= '1;
        cnt  <= '0;
        f    <= 1'b1;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[i]};
        if (sync[SYNC_STAGES-1] == f) cnt <= '0;
        else if (cnt == CW'(FILTER_LEN - 1)) begin
          cnt <= '0;
          f   <= sync[SYNC_STAGES-1];
        end else cnt <= cnt + 1'b1;
      end
    assign filt[i] = f;
  end
  always_ff @(posedge i2c_core_clock)
    prev <= preset ? 2'b11 : filt;
  logic start_det, stop_det, scl_rise;
  assign start_det = prev[1] & filt[1] & prev[0] & ~filt[0];
  assign stop_det  = prev[1] & filt[1] & ~prev[0] & filt[0];
  assign scl_rise  = ~prev[1] & filt[1];
  state_t state, nstate;
  logic [2:0] bitcnt, nbit;
  logic [7:0] shreg, nsh;
  logic push, partial;
  logic [12:0] ev;
  assign start_pulse = enable & start_det;
  assign stop_pulse  = enable & stop_det;
  assign bus_busy    = enable & (state != IDLE);
  // The SCL high phase that carries a START/STOP has already been counted as one bit,
  // so a byte is only truncated when a second bit (or the full eight) preceded the condition.
  assign partial = (state == ACK_A) | (state == ACK_D) | (bitcnt[2:1] != 2'b00);
  always_comb begin
    nstate = state;
    nbit   = bitcnt;
    nsh    = shreg;
    push   = 1'b0;
    ev     = '0;
    if (!enable) begin
      nstate = IDLE;
      nbit   = '0;
    end else if (start_det) begin
      push   = 1'b1;
      ev     = {(state == IDLE) ? 3'd1 : 3'd4, 8'h00, 1'b0, partial};
      nstate = ADDR;
      nbit   = '0;
    end else if (stop_det) begin
      push   = state != IDLE;
      ev     = {3'd5, 8'h00, 1'b0, partial};
      nstate = IDLE;
      nbit   = '0;
    end else if (scl_rise && state != IDLE) begin
      if (state == ACK_A || state == ACK_D) begin
        push   = 1'b1;
        ev     = {(state == ACK_A) ? 3'd2 : 3'd3, shreg, ~filt[0], 1'b0};
        nstate = DATA;
        nbit   = '0;
      end else begin
        nsh  = {shreg[6:0], filt[0]};
        nbit = bitcnt + 3'd1;
        if (bitcnt == 3'd7) nstate = (state == ADDR) ? ACK_A : ACK_D;
      end
    end
  end
  always_ff @(posedge i2c_core_clock)
    if (preset) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= nstate;
      bitcnt <= nbit;
      shreg  <= nsh;
    end
  logic [12:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, pop, wr;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign pop  = evt_valid & evt_ready;
  assign wr   = push & (~full | pop);
  always_ff @(posedge i2c_core_clock)
    if (wr) mem[wp] <= ev;
  always_ff @(posedge i2c_core_clock)
    if (preset) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + LW'(wr) - LW'(pop);
      if (push & full & ~pop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  assign evt_valid = fifo_level != '0;
  assign {evt_type, evt_data, evt_ack, evt_err} = evt_valid ? mem[rp] : 13'd0;
endmodule

// File: tb/tb_i2c_bus_monitor_fifo.sv
// tb_i2c_bus_monitor_fifo: bus-level stimulus against an event-list reference model
module tb_i2c_bus_monitor_fifo;
  localparam int H = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic preset = 1'b1, enable = 1'b0, scl = 1'b1, sda = 1'b1, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic evt_valid, evt_ack, evt_err, overflow, start_pulse, stop_pulse, bus_busy;
  logic [2:0] evt_type;
  logic [7:0] evt_data;
  logic [3:0] fifo_level;
  i2c_bus_monitor_fifo dut (
    .i2c_core_clock(clk), .preset(preset), .enable(enable), .scl_i(scl), .sda_i(sda),
    .evt_ready(evt_ready), .clr_overflow(clr_overflow), .evt_valid(evt_valid),
    .evt_type(evt_type), .evt_data(evt_data), .evt_ack(evt_ack), .evt_err(evt_err),
    .fifo_level(fifo_level), .overflow(overflow), .start_pulse(start_pulse),
    .stop_pulse(stop_pulse), .bus_busy(bus_busy)
  );
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [12:0] exp_q[$];
  bit bq[$];
  bit busy_m = 0, data_ph = 0, en_m = 0;
  function automatic void m_push(logic [2:0] t, logic [7:0] d, bit a, bit e);
    exp_q.push_back({t, d, a, e});
  endfunction
  function automatic void m_start();
    if (en_m) begin
      m_push(busy_m ? 3'd4 : 3'd1, 8'h00, 1'b0, busy_m && bq.size() >= 2);
      busy_m = 1;
      data_ph = 0;
      bq.delete();
    end
  endfunction
  function automatic void m_stop();
    if (en_m && busy_m) m_push(3'd5, 8'h00, 1'b0, bq.size() >= 2);
    busy_m = 0;
    bq.delete();
  endfunction
  function automatic void m_bit(bit b);
    logic [7:0] d;
    if (en_m && busy_m) begin
      bq.push_back(b);
      if (bq.size() == 9) begin
        for (int i = 0; i < 8; i++) d[7-i] = bq[i];
        m_push(data_ph ? 3'd3 : 3'd2, d, !bq[8], 1'b0);
        data_ph = 1;
        bq.delete();
      end
    end
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_start();
    if (!scl) begin
      sda = 1'b1; cyc(H);
      scl = 1'b1; m_bit(1'b1); cyc(H);
    end
    sda = 1'b0; m_start(); cyc(H);
    scl = 1'b0; cyc(H);
  endtask
  task automatic bus_bit(input bit b);
    sda = b; cyc(H);
    scl = 1'b1; m_bit(b); cyc(H);
    scl = 1'b0; cyc(H);
  endtask
  task automatic bus_byte(input logic [7:0] d, input bit ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    bus_bit(!ack);
  endtask
  task automatic bus_stop();
    sda = 1'b0; cyc(H);
    scl = 1'b1; m_bit(1'b0); cyc(H);
    sda = 1'b1; m_stop(); cyc(H);
  endtask
  bit auto_drain = 0;
  int ready_pct = 100, n_start = 0, n_stop = 0, max_lvl = 0;
  initial forever begin
    @(negedge clk);
    if (start_pulse) n_start++;
    if (stop_pulse) n_stop++;
    if (int'(fifo_level) > max_lvl) max_lvl = fifo_level;
    evt_ready = auto_drain && ($urandom_range(0, 99) < ready_pct);
    if (evt_valid && evt_ready) begin
      chk("evt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("evt", {evt_type, evt_data, evt_ack, evt_err}, exp_q.pop_front());
    end
  end
  task automatic drain();
    int t = 0;
    auto_drain = 1;
    while ((exp_q.size() != 0 || evt_valid) && t < 3000) begin
      cyc(1);
      t++;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_lvl", fifo_level, 0);
  endtask
  initial begin
    int s0, p0;
    cyc(3);
    chk("in_reset", {evt_valid, evt_type, evt_data, evt_ack, evt_err, fifo_level, overflow,
                     start_pulse, stop_pulse, bus_busy}, 0);
    preset = 1'b0; enable = 1'b1; en_m = 1;
    cyc(12);
    chk("after_reset", {evt_valid, fifo_level, overflow, start_pulse, stop_pulse, bus_busy}, 0);
    ready_pct = 100; auto_drain = 1;
    bus_start();
    chk("busy_on", bus_busy, 1);
    bus_byte(8'hA0, 1); bus_byte(8'h5A, 1);
    bus_stop();
    chk("busy_off", bus_busy, 0);
    drain();
    ready_pct = 30; max_lvl = 0;
    bus_start(); bus_byte(8'hA1, 1); bus_byte(8'hFF, 0); bus_stop();
    drain();
    chk("max_lvl_le4", max_lvl <= 4, 1);
    ready_pct = 100; s0 = n_start;
    bus_start(); bus_byte(8'h50, 1);
    bus_bit(1); bus_bit(0); bus_bit(1);
    bus_start(); bus_byte(8'h51, 1); bus_stop();
    drain();
    chk("rstart_pulses", n_start - s0, 2);
    s0 = n_start;
    sda = 1'b0; cyc(2); sda = 1'b1; cyc(20);
    chk("glitch_pulse", n_start - s0, 0);
    chk("glitch_busy", bus_busy, 0);
    chk("glitch_lvl", fifo_level, 0);
    enable = 1'b0; en_m = 0; busy_m = 0; s0 = n_start; p0 = n_stop;
    bus_start(); bus_byte(8'h3C, 1); bus_stop();
    chk("dis_pulses", (n_start - s0) + (n_stop - p0), 0);
    chk("dis_lvl", fifo_level, 0);
    enable = 1'b1; en_m = 1; cyc(4);
    auto_drain = 0; cyc(2);
    bus_start(); bus_byte(8'h20, 1);
    for (int i = 0; i < 7; i++) bus_byte(8'($urandom), 1'($urandom));
    bus_stop();
    chk("ovf_lvl", fifo_level, 8);
    chk("ovf_flag", overflow, 1);
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);
    drain();
    bus_start(); bus_byte(8'h44, 1);
    bus_bit(1); bus_bit(0); bus_bit(1);
    auto_drain = 0; cyc(2);
    chk("pre_rst_busy", bus_busy, 1);
    chk("pre_rst_q", exp_q.size(), 0);
    preset = 1'b1; cyc(1);
    chk("rst_mid", {evt_valid, fifo_level, bus_busy}, 0);
    preset = 1'b0; exp_q.delete(); bq.delete(); busy_m = 0;
    cyc(10);
    bus_stop();
    auto_drain = 1;
    bus_start(); bus_byte(8'h46, 1); bus_byte(8'h99, 0); bus_stop();
    drain();
    ready_pct = 50;
    repeat (6) begin
      bus_start(); bus_byte(8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) bus_byte(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 8)) bus_bit(1'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          bus_start(); bus_byte(8'($urandom), 1'($urandom));
        end
      end
      bus_stop();
    end
    drain();
    chk("end_ovf", overflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1);
  end
endmodule
